encoder4_2_behav_ifelse: RTL and testbench

// - 4-to-2 priority encoder with enable and registered outputs.
// - Converts a 4-bit request vector (Y3..Y0) to a 2-bit binary index (A1,A0).
// - Flags "any input active" and "more than one input active".
// - Used as a small index-generation leaf wherever one-hot/request lines need binary form.
//

---
 rtl/encoder4_2_behav_ifelse_pkg.sv | 14 +
 rtl/encoder4_2_behav_ifelse_if.sv | 14 +
 rtl/encoder4_2_behav_ifelse_prio_core.sv | 30 +++
 rtl/encoder4_2_behav_ifelse.sv | 42 ++++
 tb/tb_encoder4_2_behav_ifelse.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/encoder4_2_behav_ifelse_pkg.sv
// Shared types and helpers for the 4-to-2 priority encoder slice.
package encoder4_2_behav_ifelse_pkg;

    typedef logic [1:0] idx_t;
    typedef logic [3:0] req_t;

    // Clearing the lowest set bit leaves a nonzero value only if at least two bits were set.
    function automatic logic two_or_more(input req_t req);
        req_t low_cleared;
        low_cleared = req & (req - 4'd1);
        return low_cleared != '0;
    endfunction

endpackage

// File: rtl/encoder4_2_behav_ifelse_if.sv
// Request/result bundle between a request source and the priority-encode core.
interface encoder4_2_behav_ifelse_if;
    import encoder4_2_behav_ifelse_pkg::*;

    logic en;
    req_t req;
    idx_t idx;
    logic any;
    logic multi;

    modport master (output en, req, input idx, any, multi);
    modport slave  (input en, req, output idx, any, multi);

endinterface

// File: rtl/encoder4_2_behav_ifelse_prio_core.sv
// Combinational 4-to-2 priority encode core; req[3] has the highest priority.
module enc4_2_prio_core
    import encoder4_2_behav_ifelse_pkg::*;
(
    encoder4_2_behav_ifelse_if.slave bus
);

    always_comb begin
        bus.idx   = '0;
        bus.any   = 1'b0;
        bus.multi = 1'b0;
        if (bus.en) begin
            if (bus.req[3]) begin
                bus.idx = 2'b11;
                bus.any = 1'b1;
            end else if (bus.req[2]) begin
                bus.idx = 2'b10;
                bus.any = 1'b1;
            end else if (bus.req[1]) begin
                bus.idx = 2'b01;
                bus.any = 1'b1;
            end else if (bus.req[0]) begin
                bus.idx = 2'b00;
                bus.any = 1'b1;
            end
            bus.multi = two_or_more(bus.req);
        end
    end

endmodule

// File: rtl/encoder4_2_behav_ifelse.sv
// Registered 4-to-2 priority encoder with enable, any-active and multi-active flags.
module encoder4_2_behav_ifelse
    import encoder4_2_behav_ifelse_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic Y3,
    input  logic Y2,
    input  logic Y1,
    input  logic Y0,
    output logic A1,
    output logic A0,
    output logic valid,
    output logic multi
);

    // Flat ports are kept for drop-in use; the core talks over the bundle internally.
    encoder4_2_behav_ifelse_if core_bus ();

    assign core_bus.en  = en;
    assign core_bus.req = {Y3, Y2, Y1, Y0};

    enc4_2_prio_core u_core (
        .bus (core_bus.slave)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            A1    <= 1'b0;
            A0    <= 1'b0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else begin
            A1    <= core_bus.idx[1];
            A0    <= core_bus.idx[0];
            valid <= core_bus.any;
            multi <= core_bus.multi;
        end
    end

endmodule

// File: tb/tb_encoder4_2_behav_ifelse.sv
// Self-checking bench for encoder4_2_behav_ifelse against a behavioural reference model.
module tb_encoder4_2_behav_ifelse;

    logic clk;
    logic rst;
    logic A1, A0, valid, multi;
    int unsigned n_cmp;
    int unsigned n_bad;

    encoder4_2_behav_ifelse_if stim ();

    encoder4_2_behav_ifelse dut (
        .clk   (clk),
        .rst   (rst),
        .en    (stim.en),
        .Y3    (stim.req[3]),
        .Y2    (stim.req[2]),
        .Y1    (stim.req[1]),
        .Y0    (stim.req[0]),
        .A1    (A1),
        .A0    (A0),
        .valid (valid),
        .multi (multi)
    );

    assign stim.idx   = '0;
    assign stim.any   = 1'b0;
    assign stim.multi = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {A1,A0,valid,multi}: index of highest set bit, nonzero flag, count >= 2.
    function automatic logic [3:0] model(input logic e, input logic [3:0] y);
        int unsigned top;
        int unsigned cnt;
        top = 0;
        cnt = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (y[i]) begin
                top = i;
                cnt++;
            end
        end
        if (!e) return 4'b0000;
        return {top[1:0], cnt >= 1, cnt >= 2};
    endfunction

    task automatic step(input logic r, input logic e, input logic [3:0] y);
        rst      = r;
        stim.en  = e;
        stim.req = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 4'b1111);
        step(1'b1, 1'b1, 4'b1111);
        n_cmp++;
        if ({A1, A0, valid, multi} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset: got %b required 0000", {A1, A0, valid, multi});
        end
        step(1'b0, 1'b0, 4'b1000);
        n_cmp++;
        if ({A1, A0, valid, multi} !== 4'b0000) begin
            n_bad++;
            $display("FAIL en_off: got %b required 0000", {A1, A0, valid, multi});
        end
    endtask

    task automatic test_onehot();
        logic [3:0] pats [4];
        logic [3:0] want [4];
        pats = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        want = '{4'b1110, 4'b1010, 4'b0110, 4'b0010};
        for (int unsigned i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, pats[i]);
            n_cmp++;
            if ({A1, A0, valid, multi} !== want[i]) begin
                n_bad++;
                $display("FAIL onehot Y=%b: got %b required %b", pats[i], {A1, A0, valid, multi}, want[i]);
            end
        end
    endtask

    task automatic test_multi();
        step(1'b0, 1'b1, 4'b0110);
        n_cmp++;
        if ({A1, A0, valid, multi} !== 4'b1011) begin
            n_bad++;
            $display("FAIL multi_0110: got %b required 1011", {A1, A0, valid, multi});
        end
        step(1'b0, 1'b1, 4'b1111);
        n_cmp++;
        if ({A1, A0, valid, multi} !== 4'b1111) begin
            n_bad++;
            $display("FAIL multi_1111: got %b required 1111", {A1, A0, valid, multi});
        end
    endtask

    task automatic test_zero();
        step(1'b0, 1'b1, 4'b0000);
        n_cmp++;
        if ({A1, A0, valid, multi} !== 4'b0000) begin
            n_bad++;
            $display("FAIL zero: got %b required 0000", {A1, A0, valid, multi});
        end
    endtask

    task automatic test_mid_reset();
        step(1'b0, 1'b1, 4'b1000);
        n_cmp++;
        if ({A1, A0, valid, multi} !== 4'b1110) begin
            n_bad++;
            $display("FAIL midrst_pre: got %b required 1110", {A1, A0, valid, multi});
        end
        step(1'b1, 1'b1, 4'b1000);
        n_cmp++;
        if ({A1, A0, valid, multi} !== 4'b0000) begin
            n_bad++;
            $display("FAIL midrst_hold: got %b required 0000", {A1, A0, valid, multi});
        end
        step(1'b0, 1'b1, 4'b1000);
        n_cmp++;
        if ({A1, A0, valid, multi} !== 4'b1110) begin
            n_bad++;
            $display("FAIL midrst_resume: got %b required 1110", {A1, A0, valid, multi});
        end
    endtask

    task automatic test_sweep();
        logic [4:0] combo;
        logic [3:0] exp;
        for (int unsigned i = 0; i < 32; i++) begin
            combo = i[4:0];
            exp = model(combo[4], combo[3:0]);
            step(1'b0, combo[4], combo[3:0]);
            n_cmp++;
            if ({A1, A0, valid, multi} !== exp) begin
                n_bad++;
                $display("FAIL sweep en=%b Y=%b: got %b required %b",
                         combo[4], combo[3:0], {A1, A0, valid, multi}, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] y;
        logic       e;
        logic       r;
        logic [3:0] exp;
        for (int unsigned i = 0; i < 200; i++) begin
            y = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 15) == 0);
            exp = r ? 4'b0000 : model(e, y);
            step(r, e, y);
            n_cmp++;
            if ({A1, A0, valid, multi} !== exp) begin
                n_bad++;
                $display("FAIL random rst=%b en=%b Y=%b: got %b required %b",
                         r, e, y, {A1, A0, valid, multi}, exp);
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        stim.en  = 1'b0;
        stim.req = '0;
        #1;
        test_reset();
        test_onehot();
        test_multi();
        test_zero();
        test_mid_reset();
        test_sweep();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
